// File: rtl/multi_button_pulse_gen_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// multi_button_pulse_gen_if : button inputs, timing controls and pulse outputs
// Rev 1.0
// ----------------------------------------------------------------------------
interface multi_button_pulse_gen_if #(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 32
);
    logic [NUM_CH-1:0] i_button;
    logic [CNT_W-1:0]  i_hold_count;
    logic              i_repeat_en;
    logic [CNT_W-1:0]  i_repeat_delay;
    logic [CNT_W-1:0]  i_repeat_period;
    logic [NUM_CH-1:0] o_pulse;
    logic [NUM_CH-1:0] o_release;
    logic [NUM_CH-1:0] o_held;

    modport master (
        output i_button, i_hold_count, i_repeat_en, i_repeat_delay, i_repeat_period,
        input  o_pulse, o_release, o_held
    );

    modport slave (
        input  i_button, i_hold_count, i_repeat_en, i_repeat_delay, i_repeat_period,
        output o_pulse, o_release, o_held
    );
endinterface
`default_nettype wire

// File: rtl/multi_button_pulse_gen.sv
`default_nettype none
// ----------------------------------------------------------------------------
// multi_button_pulse_gen : per-channel sync, debounce, press/repeat/release pulses
// Rev 1.0
// ----------------------------------------------------------------------------
module multi_button_pulse_gen #(
    parameter int NUM_CH      = 4,
    parameter int CNT_W       = 32,
    parameter int SYNC_STAGES = 2
) (
    input  wire logic                  i_clk,
    input  wire logic                  i_rst_n,
    multi_button_pulse_gen_if.slave    bus
);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_DEBOUNCE = 2'd1,
        ST_HELD     = 2'd2,
        ST_REPEAT   = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] c_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [SYNC_STAGES-1:0] r_sync  [NUM_CH];
    state_t                 r_state [NUM_CH];
    logic [CNT_W-1:0]       r_cnt   [NUM_CH];
    logic [NUM_CH-1:0]      r_pulse;
    logic [NUM_CH-1:0]      r_release;
    logic [NUM_CH-1:0]      r_held;
    logic [NUM_CH-1:0]      w_btn_s;
    logic [CNT_W-1:0]       w_hold;
    logic [CNT_W-1:0]       w_delay;
    logic [CNT_W-1:0]       w_period;

    // A zero threshold behaves as one so every state always makes progress.
    assign w_hold   = (bus.i_hold_count    == '0) ? c_ONE : bus.i_hold_count;
    assign w_delay  = (bus.i_repeat_delay  == '0) ? c_ONE : bus.i_repeat_delay;
    assign w_period = (bus.i_repeat_period == '0) ? c_ONE : bus.i_repeat_period;

    function automatic logic [CNT_W-1:0] f_sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + c_ONE;
    endfunction

    always_comb begin
        w_btn_s = '0;
        for (int ch = 0; ch < NUM_CH; ch++) begin
            w_btn_s[ch] = r_sync[ch][SYNC_STAGES-1];
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            for (int ch = 0; ch < NUM_CH; ch++) begin
                r_sync[ch]  <= '0;
                r_state[ch] <= ST_IDLE;
                r_cnt[ch]   <= '0;
            end
            r_pulse   <= '0;
            r_release <= '0;
            r_held    <= '0;
        end else begin
            for (int ch = 0; ch < NUM_CH; ch++) begin
                r_sync[ch]     <= {r_sync[ch][SYNC_STAGES-2:0], bus.i_button[ch]};
                r_pulse[ch]    <= 1'b0;
                r_release[ch]  <= 1'b0;
                case (r_state[ch])
                    ST_IDLE: begin
                        r_held[ch] <= 1'b0;
                        if (w_btn_s[ch]) begin
                            r_state[ch] <= ST_DEBOUNCE;
                            r_cnt[ch]   <= c_ONE;
                        end else begin
                            r_cnt[ch]   <= '0;
                        end
                    end
                    ST_DEBOUNCE: begin
                        // cnt holds the number of stable cycles already seen here
                        if (!w_btn_s[ch]) begin
                            r_state[ch] <= ST_IDLE;
                            r_cnt[ch]   <= '0;
                            r_held[ch]  <= 1'b0;
                        end else if (r_cnt[ch] >= w_hold) begin
                            r_state[ch] <= ST_HELD;
                            r_cnt[ch]   <= '0;
                            r_pulse[ch] <= 1'b1;
                            r_held[ch]  <= 1'b1;
                        end else begin
                            r_cnt[ch]   <= f_sat_inc(r_cnt[ch]);
                            r_held[ch]  <= 1'b0;
                        end
                    end
                    ST_HELD: begin
                        if (!w_btn_s[ch]) begin
                            r_state[ch]   <= ST_IDLE;
                            r_cnt[ch]     <= '0;
                            r_release[ch] <= 1'b1;
                            r_held[ch]    <= 1'b0;
                        end else if (bus.i_repeat_en) begin
                            r_held[ch] <= 1'b1;
                            if (f_sat_inc(r_cnt[ch]) >= w_delay) begin
                                r_state[ch] <= ST_REPEAT;
                                r_cnt[ch]   <= '0;
                                r_pulse[ch] <= 1'b1;
                            end else begin
                                r_cnt[ch]   <= f_sat_inc(r_cnt[ch]);
                            end
                        end else begin
                            r_cnt[ch]  <= '0;
                            r_held[ch] <= 1'b1;
                        end
                    end
                    ST_REPEAT: begin
                        if (!w_btn_s[ch]) begin
                            r_state[ch]   <= ST_IDLE;
                            r_cnt[ch]     <= '0;
                            r_release[ch] <= 1'b1;
                            r_held[ch]    <= 1'b0;
                        end else if (!bus.i_repeat_en) begin
                            r_state[ch] <= ST_HELD;
                            r_cnt[ch]   <= '0;
                            r_held[ch]  <= 1'b1;
                        end else begin
                            r_held[ch] <= 1'b1;
                            if (f_sat_inc(r_cnt[ch]) >= w_period) begin
                                r_cnt[ch]   <= '0;
                                r_pulse[ch] <= 1'b1;
                            end else begin
                                r_cnt[ch]   <= f_sat_inc(r_cnt[ch]);
                            end
                        end
                    end
                    default: begin
                        r_state[ch] <= ST_IDLE;
                        r_cnt[ch]   <= '0;
                        r_held[ch]  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.o_pulse   = r_pulse;
    assign bus.o_release = r_release;
    assign bus.o_held    = r_held;

endmodule
`default_nettype wire

// File: tb/tb_multi_button_pulse_gen.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_multi_button_pulse_gen : directed self-checking bench
// Rev 1.0
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_multi_button_pulse_gen;

    localparam int NUM_CH      = 4;
    localparam int CNT_W       = 32;
    localparam int SYNC_STAGES = 2;

    logic i_clk   = 1'b0;
    logic i_rst_n = 1'b0;

    multi_button_pulse_gen_if #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) bus ();

    multi_button_pulse_gen #(
        .NUM_CH      (NUM_CH),
        .CNT_W       (CNT_W),
        .SYNC_STAGES (SYNC_STAGES)
    ) dut (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .bus     (bus)
    );

    always #5 i_clk = ~i_clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int overlap  = 0;
    int base     = 0;
    int pulse_q [NUM_CH][$];
    int rel_q   [NUM_CH][$];

    task automatic check(input string tag, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // Each tick lands 1ns after a rising edge; cyc stamps that edge.
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge i_clk);
            #1;
            cyc++;
            for (int ch = 0; ch < NUM_CH; ch++) begin
                if (bus.o_pulse[ch])   pulse_q[ch].push_back(cyc);
                if (bus.o_release[ch]) rel_q[ch].push_back(cyc);
                if (bus.o_pulse[ch] && bus.o_release[ch]) overlap++;
            end
        end
    endtask

    task automatic clear_mon();
        for (int ch = 0; ch < NUM_CH; ch++) begin
            pulse_q[ch].delete();
            rel_q[ch].delete();
        end
    endtask

    function automatic int pat(input int ch, input int i);
        return (pulse_q[ch].size() > i) ? pulse_q[ch][i] : -1;
    endfunction

    function automatic int rat(input int ch, input int i);
        return (rel_q[ch].size() > i) ? rel_q[ch][i] : -1;
    endfunction

    initial begin
        bus.i_button        = '1;
        bus.i_hold_count    = 32'd3;
        bus.i_repeat_en     = 1'b0;
        bus.i_repeat_delay  = 32'd1;
        bus.i_repeat_period = 32'd1;

        // Reset held with all buttons pressed
        i_rst_n = 1'b0;
        tick(3);
        check("rst_pulse",   bus.o_pulse,   0);
        check("rst_release", bus.o_release, 0);
        check("rst_held",    bus.o_held,    0);
        clear_mon();
        i_rst_n = 1'b1;
        base = cyc + 1;
        tick(8);
        check("rst_exit_pulse_cnt", pulse_q[0].size(), 1);
        check("rst_exit_pulse_at",  pat(0, 0), base + 5);
        bus.i_button = '0;
        tick(6);
        check("rst_exit_release_cnt", rel_q[0].size(), 1);

        // Debounce H=3, no repeat
        clear_mon();
        bus.i_button = 4'b0001;
        base = cyc + 1;
        tick(21);
        check("deb_pulse_cnt", pulse_q[0].size(), 1);
        check("deb_pulse_at",  pat(0, 0), base + 5);
        check("deb_held",      bus.o_held[0], 1);
        bus.i_button = 4'b0000;
        tick(6);
        check("deb_release_cnt", rel_q[0].size(), 1);
        check("deb_release_at",  rat(0, 0), base + 23);
        check("deb_held_after",  bus.o_held[0], 0);
        check("deb_pulse_cnt2",  pulse_q[0].size(), 1);

        // Glitch rejection H=5, then a full-latency re-press
        bus.i_hold_count = 32'd5;
        clear_mon();
        bus.i_button = 4'b0010;
        tick(3);
        bus.i_button = 4'b0000;
        tick(10);
        check("glitch_pulse_cnt",   pulse_q[1].size(), 0);
        check("glitch_release_cnt", rel_q[1].size(), 0);
        check("glitch_held",        bus.o_held[1], 0);
        clear_mon();
        bus.i_button = 4'b0010;
        base = cyc + 1;
        tick(10);
        check("repress_pulse_at", pat(1, 0), base + 7);
        bus.i_button = 4'b0000;
        tick(6);

        // Auto-repeat H=2 D=10 P=4 on ch2
        bus.i_hold_count    = 32'd2;
        bus.i_repeat_en     = 1'b1;
        bus.i_repeat_delay  = 32'd10;
        bus.i_repeat_period = 32'd4;
        clear_mon();
        bus.i_button = 4'b0100;
        base = cyc + 1;
        tick(40);
        bus.i_button = 4'b0000;
        tick(6);
        check("rep_pulse_cnt",   pulse_q[2].size(), 8);
        check("rep_press_at",    pat(2, 0), base + 4);
        check("rep_first_at",    pat(2, 1), base + 14);
        check("rep_second_at",   pat(2, 2), base + 18);
        check("rep_last_at",     pat(2, 7), base + 38);
        check("rep_release_cnt", rel_q[2].size(), 1);
        check("rep_release_at",  rat(2, 0), base + 42);

        // Simultaneous ch0/ch3, ch3 drops during debounce; P=0 acts as 1
        bus.i_hold_count    = 32'd3;
        bus.i_repeat_delay  = 32'd2;
        bus.i_repeat_period = 32'd0;
        clear_mon();
        bus.i_button = 4'b1001;
        base = cyc + 1;
        tick(3);
        bus.i_button = 4'b0001;
        tick(9);
        check("sim_ch3_pulse_cnt",   pulse_q[3].size(), 0);
        check("sim_ch3_release_cnt", rel_q[3].size(), 0);
        check("sim_ch0_press_at",    pat(0, 0), base + 5);
        check("sim_ch0_rep1_at",     pat(0, 1), base + 7);
        check("sim_ch0_rep2_at",     pat(0, 2), base + 8);
        check("sim_ch0_rep3_at",     pat(0, 3), base + 9);
        check("sim_ch0_pulse_cnt",   pulse_q[0].size(), 6);
        bus.i_button = 4'b0000;
        tick(6);

        // Reset while ch2 is repeating
        bus.i_hold_count    = 32'd2;
        bus.i_repeat_delay  = 32'd3;
        bus.i_repeat_period = 32'd2;
        clear_mon();
        bus.i_button = 4'b0100;
        base = cyc + 1;
        tick(10);
        check("mid_pulse_cnt", pulse_q[2].size(), 3);
        check("mid_held",      bus.o_held[2], 1);
        i_rst_n = 1'b0;
        tick(1);
        check("mid_rst_pulse",   bus.o_pulse,   0);
        check("mid_rst_held",    bus.o_held,    0);
        check("mid_rst_release", bus.o_release, 0);
        clear_mon();
        bus.i_button = 4'b0000;
        tick(2);
        i_rst_n = 1'b1;
        tick(6);
        check("mid_no_release", rel_q[2].size(), 0);
        check("mid_no_pulse",   pulse_q[2].size(), 0);

        check("pulse_release_overlap", overlap, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
